// File: rtl/sdram_burst_test_component.sv
// SDRAM device model: decodes commands, stores write bursts and replays read bursts after CAS latency.
// Protocol checking (err/err_code) is compiled in with SDRAM_BURST_TEST_PROTOCOL_CHECK_EN.
module sdram_burst_test_component #(
  parameter int DQ_W  = 16,
  parameter int ROW_W = 13,
  parameter int COL_W = 9,
  parameter int BA_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ROW_W-1:0]   zs_addr,
  input  logic [BA_W-1:0]    zs_ba,
  input  logic               zs_cs_n,
  input  logic               zs_ras_n,
  input  logic               zs_cas_n,
  input  logic               zs_we_n,
  input  logic               zs_cke,
  input  logic [DQ_W/8-1:0]  zs_dqm,
  inout  wire  [DQ_W-1:0]    zs_dq,
  output logic               err,
  output logic [2:0]         err_code
);

  localparam int NB    = DQ_W / 8;
  localparam int NBANK = 1 << BA_W;
  localparam int AW    = BA_W + ROW_W + COL_W;

  typedef enum logic [2:0] {
    CMD_LMR, CMD_REF, CMD_PRE, CMD_ACT, CMD_WR, CMD_RD, CMD_BST, CMD_NOP
  } cmd_t;

  typedef enum logic [1:0] {B_IDLE, B_WRITE, B_READ} burst_t;

  logic [DQ_W-1:0] mem [0:(1<<AW)-1];

  logic [1:0]                     cl_q, cl_d, bl_q, bl_d;
  logic [NBANK-1:0]               open_q, open_d;
  logic [NBANK-1:0][ROW_W-1:0]    row_q, row_d;
  burst_t                         bst_q, bst_d;
  logic [BA_W-1:0]                b_ba_q, b_ba_d;
  logic [ROW_W-1:0]               b_row_q, b_row_d;
  logic [COL_W-1:0]               b_col_q, b_col_d;
  logic [1:0]                     b_bl_q, b_bl_d;
  logic [2:0]                     b_idx_q, b_idx_d, b_last;

  logic [2:0]                     pipe_vld_q;
  logic [2:0][AW-1:0]             pipe_addr_q;
  logic [2:0][NB-1:0]             pipe_mask_q;

  cmd_t                           cmd;
  logic                           lmr_ok, stop;
  logic                           beat_vld, beat_wr;
  logic [BA_W-1:0]                beat_ba;
  logic [ROW_W-1:0]               beat_row;
  logic [COL_W-1:0]               beat_col;
  logic [AW-1:0]                  beat_addr;

  logic [1:0]                     rd_sel;
  logic                           rd_vld;
  logic [NB-1:0]                  rd_mask;
  logic [DQ_W-1:0]                rd_word;

  // Sequential column order, wrapping inside the BL-aligned block.
  function automatic logic [COL_W-1:0] col_at(input logic [COL_W-1:0] base,
                                              input logic [2:0] idx, input logic [1:0] bl);
    logic [COL_W-1:0] m;
    m = COL_W'((4'd1 << bl) - 4'd1);
    return (base & ~m) | ((base + COL_W'(idx)) & m);
  endfunction

  assign cmd    = (!zs_cs_n && zs_cke) ? cmd_t'({zs_ras_n, zs_cas_n, zs_we_n}) : CMD_NOP;
  assign lmr_ok = (zs_addr[6:4] inside {3'd1, 3'd2, 3'd3}) && (zs_addr[2:0] <= 3'd3);
  assign stop   = (cmd == CMD_BST) ||
                  (cmd == CMD_PRE && (zs_addr[10] || zs_ba == b_ba_q));
  assign b_last = 3'((4'd1 << b_bl_q) - 4'd1);

  always_comb begin
    cl_d     = cl_q;
    bl_d     = bl_q;
    open_d   = open_q;
    row_d    = row_q;
    bst_d    = bst_q;
    b_ba_d   = b_ba_q;
    b_row_d  = b_row_q;
    b_col_d  = b_col_q;
    b_bl_d   = b_bl_q;
    b_idx_d  = b_idx_q;
    beat_vld = 1'b0;
    beat_wr  = 1'b0;
    beat_ba  = b_ba_q;
    beat_row = b_row_q;
    beat_col = col_at(b_col_q, b_idx_q, b_bl_q);

    case (cmd)
      CMD_LMR: if (lmr_ok) begin
        cl_d = zs_addr[5:4];
        bl_d = zs_addr[1:0];
      end
      CMD_ACT: begin
        open_d[zs_ba] = 1'b1;
        row_d[zs_ba]  = zs_addr;
      end
      CMD_PRE: begin
        if (zs_addr[10]) open_d = '0;
        else             open_d[zs_ba] = 1'b0;
      end
      default: ;
    endcase

    if (cmd == CMD_WR || cmd == CMD_RD) begin
      // A new column command always wins over whatever burst was running.
      beat_vld = 1'b1;
      beat_wr  = (cmd == CMD_WR);
      beat_ba  = zs_ba;
      beat_row = row_q[zs_ba];
      beat_col = zs_addr[COL_W-1:0];
      b_ba_d   = zs_ba;
      b_row_d  = row_q[zs_ba];
      b_col_d  = zs_addr[COL_W-1:0];
      b_bl_d   = bl_q;
      b_idx_d  = 3'd1;
      if (bl_q == 2'd0)        bst_d = B_IDLE;
      else if (cmd == CMD_WR)  bst_d = B_WRITE;
      else                     bst_d = B_READ;
    end else if (bst_q != B_IDLE) begin
      if (stop) begin
        bst_d = B_IDLE;
      end else begin
        beat_vld = 1'b1;
        beat_wr  = (bst_q == B_WRITE);
        b_idx_d  = b_idx_q + 3'd1;
        if (b_idx_q == b_last) bst_d = B_IDLE;
      end
    end
  end

  assign beat_addr = {beat_ba, beat_row, beat_col};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cl_q        <= 2'd3;
      bl_q        <= 2'd0;
      open_q      <= '0;
      row_q       <= '0;
      bst_q       <= B_IDLE;
      b_ba_q      <= '0;
      b_row_q     <= '0;
      b_col_q     <= '0;
      b_bl_q      <= '0;
      b_idx_q     <= '0;
      pipe_vld_q  <= '0;
      pipe_addr_q <= '0;
      pipe_mask_q <= '0;
    end else if (zs_cke) begin
      cl_q        <= cl_d;
      bl_q        <= bl_d;
      open_q      <= open_d;
      row_q       <= row_d;
      bst_q       <= bst_d;
      b_ba_q      <= b_ba_d;
      b_row_q     <= b_row_d;
      b_col_q     <= b_col_d;
      b_bl_q      <= b_bl_d;
      b_idx_q     <= b_idx_d;
      pipe_vld_q  <= {pipe_vld_q[1:0], beat_vld & ~beat_wr};
      pipe_addr_q <= {pipe_addr_q[1:0], beat_addr};
      pipe_mask_q <= {pipe_mask_q[1:0], zs_dqm};
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!reset && zs_cke && beat_vld && beat_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (!zs_dqm[b]) mem[beat_addr][b*8 +: 8] <= zs_dq[b*8 +: 8];
      end
    end
  end

  // Stage k holds a beat issued k+1 cycles ago, so stage CL-1 is on the bus now.
  assign rd_sel  = 2'(cl_q - 2'd1);
  assign rd_vld  = pipe_vld_q[rd_sel];
  assign rd_mask = pipe_mask_q[rd_sel];
  assign rd_word = mem[pipe_addr_q[rd_sel]];

  for (genvar b = 0; b < NB; b++) begin : g_dq
    assign zs_dq[b*8 +: 8] = (rd_vld && !rd_mask[b]) ? rd_word[b*8 +: 8] : 8'bz;
  end

`ifdef SDRAM_BURST_TEST_PROTOCOL_CHECK_EN
  logic       err_hit;
  logic [2:0] err_cause;

  always_comb begin
    err_hit   = 1'b1;
    err_cause = 3'd0;
    if ((cmd == CMD_RD || cmd == CMD_WR) && !open_q[zs_ba]) err_cause = 3'd1;
    else if (cmd == CMD_ACT && open_q[zs_ba])               err_cause = 3'd2;
    else if (cmd == CMD_LMR && !lmr_ok)                     err_cause = 3'd3;
    else if (cmd == CMD_REF && |open_q)                     err_cause = 3'd4;
    else                                                    err_hit   = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      err_code <= 3'd0;
    end else if (err_hit && !err) begin
      err      <= 1'b1;
      err_code <= err_cause;
    end
  end
`else
  assign err      = 1'b0;
  assign err_code = 3'd0;
`endif

endmodule
